multicycle_control_fsm: RTL and testbench

- Main control sequencer for the multicycle RISC-V core with cache.
- Steps each instruction through Fetch/Decode/Execute/Memory/Writeback and drives the datapath mux selects, register/PC/IR enables and the 2-bit ALUOp consumed by the ALU decoder.
- Sits in the core's control unit, alongside the ALU decoder and immediate decoder.
- Handshakes with the cache controller: holds in any memory state until the cache reports completion, and aborts after a bounded wait.

---
 rtl/multicycle_control_fsm_if.sv | 32 +++
 rtl/multicycle_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle control sequencer and the datapath / cache controller.
// The master side is the sequencer: it consumes the opcode, ALU flag and cache
// completion, and drives every datapath select, enable and memory request.
interface multicycle_control_fsm_if;
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       MemErr;
  logic       Illegal;

  modport master (
    input  Op, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, MemErr, Illegal
  );

  modport slave (
    output Op, Zero, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, MemErr, Illegal
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle RISC-V core with cache.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// waits on the cache controller in FETCH, MEMREAD and MEMWRITE, aborting back
// to FETCH (MemErr pulse) after MAX_WAIT stalled cycles.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes lock the FSM in TRAP with
// Illegal=1 until reset; without it they behave as a NOP.
module multicycle_control_fsm #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input logic                    CLK,
  input logic                    RST,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t state, state_next;

  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic wait_state;
  logic timeout;

  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  // State register and wait counter; reset parks the FSM in FETCH with no wait history.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout    = wait_state && !bus.MemReady && (wait_cnt == WAIT_W'(MAX_WAIT));

  // Next-state, wait-count and datapath control decode; completion takes priority over timeout.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    if (wait_state && !bus.MemReady && (wait_cnt < WAIT_W'(MAX_WAIT))) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end

    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        if (bus.MemReady) state_next = DECODE;
        else if (timeout) state_next = FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.Op)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECR;
          7'b0010011:             state_next = EXECI;
          7'b1100011:             state_next = BEQ;
          7'b1101111:             state_next = JAL;
`ifdef ILLEGAL_TRAP_EN
          default:                state_next = TRAP;
`else
          default:                state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = bus.Op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (bus.MemReady) state_next = MEMWB;
        else if (timeout) state_next = FETCH;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady || timeout) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        pc_write   = bus.Zero;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        state_next = TRAP;
      end
`endif
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign bus.MemReq    = mem_req   & RST;
  assign bus.MemWrite  = mem_write & RST;
  assign bus.IRWrite   = ir_write  & RST;
  assign bus.PCWrite   = pc_write  & RST;
  assign bus.RegWrite  = reg_write & RST;
  assign bus.MemErr    = timeout   & RST;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;

`ifdef ILLEGAL_TRAP_EN
  assign bus.Illegal = (state == TRAP);
`else
  assign bus.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MAX_WAIT=4).
// All outputs are packed into one 16-bit word and compared each cycle against
// hand-computed per-state constants:
// {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,MemErr,Illegal,
//  ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  localparam logic [15:0] E_RESET    = 16'h0088;
  localparam logic [15:0] E_FETCH_W  = 16'h8088;
  localparam logic [15:0] E_FETCH_GO = 16'h9888;
  localparam logic [15:0] E_FETCH_TO = 16'h8288;
  localparam logic [15:0] E_DECODE   = 16'h0014;
  localparam logic [15:0] E_MEMADR   = 16'h0024;
  localparam logic [15:0] E_MEMREAD  = 16'hA000;
  localparam logic [15:0] E_MEMWB    = 16'h0440;
  localparam logic [15:0] E_MEMWRITE = 16'hE000;
  localparam logic [15:0] E_MEMWR_TO = 16'hE200;
  localparam logic [15:0] E_EXECR    = 16'h0022;
  localparam logic [15:0] E_EXECI    = 16'h0026;
  localparam logic [15:0] E_ALUWB    = 16'h0400;
  localparam logic [15:0] E_BEQ_T    = 16'h0821;
  localparam logic [15:0] E_BEQ_F    = 16'h0021;
  localparam logic [15:0] E_JAL      = 16'h0818;
  localparam logic [15:0] E_TRAP     = 16'h0100;

  logic CLK;
  logic RST;
  int   checkCount = 0;
  int   errCount   = 0;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [15:0] obs;
  assign obs = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                bus.RegWrite, bus.MemErr, bus.Illegal, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};

  // Free-running clock, 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, check mid-cycle, then step.
  task automatic applyStimulus(input string tag, input logic [6:0] op,
                               input logic zero, input logic rdy,
                               input logic [15:0] expected);
    bus.Op       = op;
    bus.Zero     = zero;
    bus.MemReady = rdy;
    @(negedge CLK);
    checkOutput(tag, obs, expected);
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseReset();
    #2 RST = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    RST          = 1'b0;
    bus.Op       = 7'b0;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;
    #2;
    checkOutput("reset_async", obs, E_RESET);
    bus.MemReady = 1'b1;
    #1;
    checkOutput("reset_gate", obs, E_RESET);
    @(posedge CLK);
    #1;
    checkOutput("reset_held", obs, E_RESET);
    RST = 1'b1;

    // lw with fetch and memory stalls
    applyStimulus("lw_f0",  OP_LW, 0, 0, E_FETCH_W);
    applyStimulus("lw_f1",  OP_LW, 0, 0, E_FETCH_W);
    applyStimulus("lw_f2",  OP_LW, 0, 1, E_FETCH_GO);
    applyStimulus("lw_dec", OP_LW, 0, 0, E_DECODE);
    applyStimulus("lw_adr", OP_LW, 0, 0, E_MEMADR);
    applyStimulus("lw_rd0", OP_LW, 0, 0, E_MEMREAD);
    applyStimulus("lw_rd1", OP_LW, 0, 0, E_MEMREAD);
    applyStimulus("lw_rd2", OP_LW, 0, 0, E_MEMREAD);
    applyStimulus("lw_rd3", OP_LW, 0, 1, E_MEMREAD);
    applyStimulus("lw_wb",  OP_LW, 0, 1, E_MEMWB);

    // add (MemReady ignored outside wait states)
    applyStimulus("add_f",   OP_ADD, 0, 1, E_FETCH_GO);
    applyStimulus("add_dec", OP_ADD, 0, 1, E_DECODE);
    applyStimulus("add_ex",  OP_ADD, 0, 1, E_EXECR);
    applyStimulus("add_wb",  OP_ADD, 0, 1, E_ALUWB);

    // addi
    applyStimulus("addi_f",   OP_ADDI, 0, 1, E_FETCH_GO);
    applyStimulus("addi_dec", OP_ADDI, 0, 0, E_DECODE);
    applyStimulus("addi_ex",  OP_ADDI, 0, 0, E_EXECI);
    applyStimulus("addi_wb",  OP_ADDI, 0, 0, E_ALUWB);

    // beq taken then not taken
    applyStimulus("beqt_f",   OP_BEQ, 1, 1, E_FETCH_GO);
    applyStimulus("beqt_dec", OP_BEQ, 1, 0, E_DECODE);
    applyStimulus("beqt_ex",  OP_BEQ, 1, 0, E_BEQ_T);
    applyStimulus("beqf_f",   OP_BEQ, 0, 1, E_FETCH_GO);
    applyStimulus("beqf_dec", OP_BEQ, 0, 0, E_DECODE);
    applyStimulus("beqf_ex",  OP_BEQ, 0, 0, E_BEQ_F);

    // jal
    applyStimulus("jal_f",   OP_JAL, 0, 1, E_FETCH_GO);
    applyStimulus("jal_dec", OP_JAL, 0, 0, E_DECODE);
    applyStimulus("jal_ex",  OP_JAL, 0, 0, E_JAL);
    applyStimulus("jal_wb",  OP_JAL, 0, 0, E_ALUWB);

    // sw with MemReady held low: abort after MAX_WAIT stalled cycles
    applyStimulus("sw_f",    OP_SW, 0, 1, E_FETCH_GO);
    applyStimulus("sw_dec",  OP_SW, 0, 0, E_DECODE);
    applyStimulus("sw_adr",  OP_SW, 0, 0, E_MEMADR);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("sw_wait%0d", i), OP_SW, 0, 0, E_MEMWRITE);
    applyStimulus("sw_timeout", OP_SW, 0, 0, E_MEMWR_TO);
    applyStimulus("sw_refetch", OP_SW, 0, 0, E_FETCH_W);
    applyStimulus("sw2_f",   OP_SW, 0, 1, E_FETCH_GO);
    applyStimulus("sw2_dec", OP_SW, 0, 0, E_DECODE);
    applyStimulus("sw2_adr", OP_SW, 0, 0, E_MEMADR);
    applyStimulus("sw2_wr",  OP_SW, 0, 1, E_MEMWRITE);

    // completion on the timeout cycle wins over the abort
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("race_wait%0d", i), OP_ADD, 0, 0, E_FETCH_W);
    applyStimulus("race_done", OP_ADD, 0, 1, E_FETCH_GO);
    applyStimulus("race_dec",  OP_ADD, 0, 0, E_DECODE);
    applyStimulus("race_ex",   OP_ADD, 0, 0, E_EXECR);
    applyStimulus("race_wb",   OP_ADD, 0, 0, E_ALUWB);

    // timeout in FETCH refetches with the counter restarted
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("fto_wait%0d", i), OP_ADD, 0, 0, E_FETCH_W);
    applyStimulus("fto_abort", OP_ADD, 0, 0, E_FETCH_TO);
    applyStimulus("fto_again", OP_ADD, 0, 0, E_FETCH_W);
    applyStimulus("fto_go",    OP_ADD, 0, 1, E_FETCH_GO);
    applyStimulus("fto_dec",   OP_ADD, 0, 0, E_DECODE);
    applyStimulus("fto_ex",    OP_ADD, 0, 0, E_EXECR);
    applyStimulus("fto_wb",    OP_ADD, 0, 0, E_ALUWB);

    // unsupported opcode
    applyStimulus("bad_f",   OP_BAD, 0, 1, E_FETCH_GO);
    applyStimulus("bad_dec", OP_BAD, 0, 0, E_DECODE);
`ifdef ILLEGAL_TRAP_EN
    applyStimulus("bad_trap0", OP_BAD, 0, 1, E_TRAP);
    applyStimulus("bad_trap1", OP_ADD, 1, 1, E_TRAP);
`else
    applyStimulus("bad_nop",   OP_BAD, 0, 0, E_FETCH_W);
`endif
    pulseReset();

    // reset asserted during a MEMREAD stall
    applyStimulus("rmid_f",   OP_LW, 0, 1, E_FETCH_GO);
    applyStimulus("rmid_dec", OP_LW, 0, 0, E_DECODE);
    applyStimulus("rmid_adr", OP_LW, 0, 0, E_MEMADR);
    applyStimulus("rmid_rd0", OP_LW, 0, 0, E_MEMREAD);
    applyStimulus("rmid_rd1", OP_LW, 0, 0, E_MEMREAD);
    #2 RST = 1'b0;
    #1;
    checkOutput("rmid_drop", obs, E_RESET);
    @(posedge CLK);
    #1 RST = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("rmid_wait%0d", i), OP_LW, 0, 0, E_FETCH_W);
    applyStimulus("rmid_timeout", OP_LW, 0, 0, E_FETCH_TO);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
